// File: rtl/feature_pkg.sv
// Shared audio front-end parameters and types (splitter, hamming, FFT, mel).
package feature_pkg;

    localparam int FEAT_DW        = 32;   // sample width
    localparam int FEAT_FRAME_LEN = 256;  // samples per frame, equals FFT size
    localparam int FEAT_HOP       = 128;  // offset between frame starts
    localparam int FEAT_DEPTH     = 512;  // sample buffer depth, power of 2

    // Per-beat position tag that travels alongside a sample through the
    // read pipeline so it leaves together with its data.
    typedef struct packed {
        logic       first;
        logic       last;
        logic [7:0] index;
    } beat_tag_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// No reset; contents are only ever read after being written.
module sample_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // read port; rdata holds when re is low so a stalled beat is not lost
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/frame_splitter.sv
// Splits a continuous sample stream into overlapping frames of FRAME_LEN
// samples, consecutive frames starting HOP samples apart.
module frame_splitter
    import feature_pkg::*;
#(
    parameter int DW        = FEAT_DW,
    parameter int FRAME_LEN = FEAT_FRAME_LEN,
    parameter int HOP       = FEAT_HOP,
    parameter int DEPTH     = FEAT_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_index,
    output logic          out_first,
    output logic          out_last,
    output logic [15:0]   frame_cnt
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = AW + 1;              // extra bit separates full from empty
    localparam int CW     = $clog2(FRAME_LEN) + 1;
    localparam int STAGES = 2;                   // RAM read + output register

    localparam logic [0:0] FILL   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]        state;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     frame_base;
    logic [PW-1:0]     fill;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     iss_cnt;     // reads issued for the current frame
    logic              rdy_en;
    logic [STAGES-1:0] vld_pipe;    // [0] RAM data valid, [1] output valid
    beat_tag_t         s1_tag;
    logic [DW-1:0]     ram_rdata;
    logic              wr_en;
    logic              load;
    logic              issue;
    logic              last_acc;

    assign fill     = wr_ptr - frame_base;
    // fill never exceeds DEPTH, so its top bit set means the buffer is full
    assign in_ready = rdy_en && !fill[AW];
    assign wr_en    = in_valid && in_ready;
    assign out_valid = vld_pipe[1];
    // output register may take a new beat when empty or being drained
    assign load     = !vld_pipe[1] || out_ready;
    // a read is issued only when the RAM stage has room to move forward
    assign issue    = (state == STREAM) && (iss_cnt < CW'(FRAME_LEN))
                      && (!vld_pipe[0] || load);
    assign last_acc = vld_pipe[1] && out_ready && out_last;

    sample_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // in_ready is held low until the first edge out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en <= 1'b0;
        else     rdy_en <= 1'b1;
    end

    // write pointer, independent of frame_base so both may move together
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        wr_ptr <= '0;
        else if (wr_en) wr_ptr <= wr_ptr + PW'(1);
    end

    // frame sequencing: wait for a full frame, stream it, then hop forward
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            rd_ptr     <= '0;
            iss_cnt    <= '0;
            frame_base <= '0;
            frame_cnt  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (fill >= PW'(FRAME_LEN)) begin
                        state   <= STREAM;
                        rd_ptr  <= frame_base[AW-1:0];
                        iss_cnt <= '0;
                    end
                end
                default: begin
                    if (issue) begin
                        rd_ptr  <= rd_ptr + AW'(1);
                        iss_cnt <= iss_cnt + CW'(1);
                    end
                    if (last_acc) begin
                        state      <= FILL;
                        frame_base <= frame_base + PW'(HOP);
                        frame_cnt  <= frame_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // two-stage read pipeline with backpressure; output holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            s1_tag    <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            vld_pipe[0] <= issue || (vld_pipe[0] && !load);
            if (issue) begin
                s1_tag.first <= (iss_cnt == '0);
                s1_tag.last  <= (iss_cnt == CW'(FRAME_LEN - 1));
                s1_tag.index <= 8'(iss_cnt);
            end
            if (load) begin
                vld_pipe[1] <= vld_pipe[0];
                if (vld_pipe[0]) begin
                    out_data  <= ram_rdata;
                    out_index <= s1_tag.index;
                    out_first <= s1_tag.first;
                    out_last  <= s1_tag.last;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_splitter.sv
// Randomized bench for frame_splitter against a frame/hop reference model.
module tb_frame_splitter;

    localparam int DW    = 32;
    localparam int FL    = 256;
    localparam int HOP   = 128;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_index;
    logic          out_first;
    logic          out_last;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    frame_splitter #(.DW(DW), .FRAME_LEN(FL), .HOP(HOP), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_first (out_first),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    int n_err = 0;
    int n_chk = 0;

    // reference model: every accepted input since reset, plus the position
    // (frame mk, offset midx) of the next beat the splitter must emit
    logic [DW-1:0] hist[$];
    int            mk   = 0;
    int            midx = 0;

    // stimulus knobs
    int            tgt   = 0;   // total samples to offer since reset
    int            p_in  = 100; // percent chance in_valid per cycle
    int            p_out = 100; // percent chance out_ready per cycle
    bit            rnd   = 1'b0;
    logic [DW-1:0] dbase = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // handshakes are judged at the negedge, valid through the next posedge
    always @(negedge clk) begin
        int pos;
        if (!rst) begin
            if (out_valid && out_ready) begin
                pos = mk * HOP + midx;
                if (pos < int'(hist.size())) chk("data", out_data, hist[pos]);
                else                         chk("early", pos, hist.size());
                chk("index", {24'd0, out_index}, midx);
                chk("flags", {30'd0, out_first, out_last}, {30'd0, midx == 0, midx == FL - 1});
                midx++;
                if (midx == FL) begin
                    midx = 0;
                    mk++;
                end
            end
            if (in_valid && in_ready) hist.push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (int'(hist.size()) < tgt && int'($urandom_range(99)) < p_in) begin
            in_valid = 1'b1;
            in_data  = rnd ? DW'($urandom) : dbase + 32'(hist.size());
        end else begin
            in_valid = 1'b0;
        end
        out_ready = int'($urandom_range(99)) < p_out;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic run_frames(input int n, input int maxc);
        int c = 0;
        while (mk < n && c < maxc) begin
            step();
            c++;
        end
        chk("frames_reached", mk, n);
        chk("frame_cnt", {16'd0, frame_cnt}, n);
    endtask

    // assert reset, check the forced state, release and check in_ready rise
    task automatic do_reset();
        rst       = 1'b1;
        #1;
        chk("rst_data", out_data, 0);
        chk("rst_ctl", {28'd0, out_valid, out_first, out_last, in_ready}, 0);
        chk("rst_idx_cnt", {8'd0, out_index, frame_cnt}, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        hist.delete();
        mk   = 0;
        midx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", {31'd0, in_ready}, 0);
        @(negedge clk);
        chk("ready_after_edge", {31'd0, in_ready}, 1);
    endtask

    initial begin
        logic [3:0] v;
        bit         hit;
        int         c;

        // frame 0 from 0..255, with the valid latency around the 256th sample
        do_reset();
        rnd = 1'b0; dbase = '0; p_in = 100; p_out = 100;
        tgt = FL - 1;
        hit = 1'b0;
        repeat (300) begin
            step();
            hit = hit | out_valid;
        end
        chk("no_valid_255", {31'd0, hit}, 0);
        chk("accepted_255", hist.size(), FL - 1);
        tgt = FL;
        step();                      // offer sample 255
        step();                      // written on this edge
        @(negedge clk) v[3] = out_valid;
        step(); @(negedge clk) v[2] = out_valid;
        step(); @(negedge clk) v[1] = out_valid;
        step(); @(negedge clk) v[0] = out_valid;
        chk("first_valid_lat", {28'd0, v}, 4'b0001);
        run_frames(1, 600);

        // 0..1023 continuous: frames at 0,128,...,768 and nothing more
        do_reset();
        tgt = 1024;
        run_frames(7, 3000);
        run_cycles(20);
        chk("no_frame_7", {31'd0, out_valid}, 0);
        chk("frame_cnt_7", {16'd0, frame_cnt}, 7);

        // downstream stalled: buffer fills to DEPTH, then drains losslessly
        do_reset();
        tgt = 1024; p_out = 0;
        run_cycles(600);
        chk("stall_writes", hist.size(), DEPTH);
        chk("stall_ready", {31'd0, in_ready}, 0);
        chk("stall_valid", {31'd0, out_valid}, 1);
        chk("stall_data", out_data, 0);
        chk("stall_index", {24'd0, out_index}, 0);
        p_out = 100;
        run_frames(7, 3000);

        // random traffic and random data across many pointer wraps
        do_reset();
        rnd = 1'b1; p_in = 70; p_out = 50; tgt = 5000;
        run_frames((5000 - FL) / HOP + 1, 40000);

        // reset in the middle of frame 3, then restart with fresh data
        do_reset();
        rnd = 1'b0; p_in = 100; p_out = 100; tgt = 2000;
        hit = 1'b0;
        c   = 0;
        while (!hit && c < 3000) begin
            step();
            hit = out_valid && frame_cnt == 16'd3 && out_index == 8'd100;
            c++;
        end
        chk("hit_f3_i100", {31'd0, hit}, 1);
        do_reset();
        dbase = 32'h0000_1000; tgt = 300;
        run_frames(1, 1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_splitter.md
FRAME_SPLITTER -- requirements
Module: frame_splitter

Interface
REQ-001 SHALL have parameter DW, default 32, meaning sample width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 256, meaning samples per frame; this matches the FFT size.
REQ-003 SHALL have parameter HOP, default 128, meaning the sample offset between consecutive frame starts.
REQ-004 SHALL have parameter DEPTH, default 512, meaning circular buffer depth; it is a power of 2 and at least FRAME_LEN+HOP.
REQ-005 SHALL have the following ports (one clock; reset is asynchronous and active-high):
  clk        in   1          rising-edge clock
  rst        in   1          asynchronous, active-high reset
  in_data    in   DW         audio sample, two's complement
  in_valid   in   1          in_data valid
  in_ready   out  1          splitter can accept a sample
  out_data   out  DW         framed sample, to the hamming window
  out_valid  out  1          out_data valid
  out_ready  in   1          downstream accepts
  out_index  out  8          position of sample in frame, 0..FRAME_LEN-1
  out_first  out  1          out_index==0
  out_last   out  1          out_index==FRAME_LEN-1
  frame_cnt  out  16         count of completed frames

Function
REQ-006 SHALL accept an input sample on a clock edge where in_valid&&in_ready, and write it at wr_ptr; wr_ptr SHALL then increment modulo DEPTH.
REQ-007 SHALL drive in_ready=1 iff (wr_ptr-frame_base) mod 2*DEPTH < DEPTH, i.e. unread samples of the current frame are never overwritten.
REQ-008 SHALL track fill = samples written since frame_base, using pointers one bit wider than log2(DEPTH) to disambiguate full from empty.
REQ-009 SHALL implement FSM states FILL and STREAM; reset state is FILL.
REQ-010 SHALL move FILL->STREAM when fill >= FRAME_LEN, with rd_ptr=frame_base and out_index=0.
REQ-011 SHALL in STREAM read buf[rd_ptr] into a registered output; the first out_valid SHALL rise exactly 2 cycles after the FILL->STREAM decision (1 RAM read + 1 output register).
REQ-012 SHALL hold out_data, out_index, out_first and out_last stable while out_valid&&!out_ready; it SHALL advance one sample per cycle when out_ready stays high (no bubbles inside a frame).
REQ-013 SHALL, on acceptance of the out_last beat: frame_base += HOP, frame_cnt += 1 (wrapping at 2^16), and go to FILL.
REQ-014 SHALL, if fill >= FRAME_LEN already holds after the frame_base update, re-enter STREAM on the next cycle; the inter-frame gap SHALL be at most 3 cycles.
REQ-015 SHALL handle a simultaneous input write and frame_base advance in the same cycle, with both updates applied.
REQ-016 SHALL handle pointer wrap past DEPTH-1 to 0 transparently; frame content SHALL be contiguous in sample order.
REQ-017 SHALL pass sample values through bit-exact; no arithmetic is applied to data.
REQ-018 SHALL guarantee that frame k contains input samples k*HOP .. k*HOP+FRAME_LEN-1 (0-based from reset).

Reset
REQ-019 SHALL, while rst=1, asynchronously force: state=FILL, wr_ptr=rd_ptr=frame_base=0, out_valid=0, out_data=0, out_index=0, out_first=0, out_last=0, frame_cnt=0, in_ready=0.
REQ-020 SHALL raise in_ready on the first clk edge after rst deasserts.
REQ-021 SHALL, on reset asserted mid-frame, discard the partial frame and leave RAM contents undefined; these contents SHALL never be emitted afterwards.

Structure
REQ-022 SHALL take FRAME_LEN, HOP, DEPTH and DW defaults from shared package feature_pkg, which the hamming, FFT_256 and Melfilter_log blocks also use.
REQ-023 SHALL place storage in one sub-module sample_ram: simple dual-port, DEPTH x DW, 1 write port, 1 synchronous read port with 1-cycle latency, no reset.
REQ-024 SHALL keep the FSM, pointers and output register in frame_splitter; total RTL 120-400 lines.

Verification
REQ-025 SHALL cover: reset, then stream in_data=0..255 with out_ready=1 -> frame 0 emits 0..255, out_first on 0, out_last on 255, frame_cnt=1.
REQ-026 SHALL cover: continuous input 0..1023 with out_ready=1 -> frames 0..6 start at 0,128,...,768, each 256 contiguous values, frame_cnt=7.
REQ-027 SHALL cover: out_ready=0 held for 600 cycles while input offered -> in_ready drops after 512 writes, out_data frozen at 0, no sample lost after release.
REQ-028 SHALL cover: random out_ready (50%) and random in_valid over 5000 samples -> scoreboard matches REQ-018 across ptr wrap.
REQ-029 SHALL cover: rst pulsed at out_index=100 of frame 3 -> all outputs zero during rst; next frame starts with the first post-reset sample; frame_cnt=0.
REQ-030 SHALL cover: 255 samples only -> out_valid stays 0; the 256th sample -> out_valid rises 2 cycles after the decision.
